// File: rtl/eth_10g_axil_regs.sv
// rtl/eth_10g_axil_regs.sv - AXI4-Lite register file: MAC config registers and frame statistics counters
module eth_10g_axil_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     ctrl_o,
    output logic [47:0]                       mac_addr_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     ifg_o,
    input  logic                              tx_frame_i,
    input  logic                              rx_frame_i,
    input  logic                              rx_err_i
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int SW = DW / 8;

    logic           rst_done;
    logic           aw_full, w_full;
    logic [3:0]     wr_idx;
    logic [DW-1:0]  wdata_q;
    logic [SW-1:0]  wstrb_q;
    logic           bvalid_q;
    logic [1:0]     bresp_q;
    logic           arready_q, rvalid_q;
    logic [1:0]     rresp_q;
    logic [DW-1:0]  rdata_q;
    logic [DW-1:0]  ctrl_q, mac_lo_q, mac_hi_q, ifg_q;
    logic [DW-1:0]  tx_cnt_q, rx_cnt_q, err_cnt_q;

    logic           aw_hs, w_hs, b_hs, ar_hs, r_hs, commit, wr_mapped;
    logic [3:0]     ar_idx;
    logic [DW-1:0]  rd_data;
    logic           rd_mapped;
    logic           unused_bits;

    function automatic logic [DW-1:0] apply_strb(input logic [DW-1:0] old_d,
                                                 input logic [DW-1:0] new_d,
                                                 input logic [SW-1:0] strb);
        logic [DW-1:0] r;
        r = old_d;
        for (int b = 0; b < SW; b++) begin
            if (strb[b]) r[8*b +: 8] = new_d[8*b +: 8];
        end
        return r;
    endfunction

    // Clear takes priority over a coincident event; the count sticks at all-ones.
    function automatic logic [DW-1:0] cnt_next(input logic [DW-1:0] cnt,
                                               input logic pulse, input logic clr);
        if (clr) return '0;
        if (pulse && cnt != '1) return cnt + DW'(1);
        return cnt;
    endfunction

    // rst_done keeps the ready outputs low while reset is held
    assign S_AXI_AWREADY = rst_done & ~aw_full & ~bvalid_q;
    assign S_AXI_WREADY  = rst_done & ~w_full & ~bvalid_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;

    assign aw_hs     = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs      = S_AXI_WVALID & S_AXI_WREADY;
    assign b_hs      = bvalid_q & S_AXI_BREADY;
    assign ar_hs     = S_AXI_ARVALID & arready_q;
    assign r_hs      = rvalid_q & S_AXI_RREADY;
    assign commit    = aw_full & w_full & ~bvalid_q;
    assign wr_mapped = (wr_idx <= 4'd6);
    assign ar_idx    = S_AXI_ARADDR[5:2];

    assign ctrl_o     = ctrl_q;
    assign mac_addr_o = {mac_hi_q[15:0], mac_lo_q};
    assign ifg_o      = ifg_q;

    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    always_comb begin
        rd_data   = '0;
        rd_mapped = 1'b1;
        case (ar_idx)
            4'd0:    rd_data = ctrl_q;
            4'd1:    rd_data = mac_lo_q;
            4'd2:    rd_data = mac_hi_q;
            4'd3:    rd_data = ifg_q;
            4'd4:    rd_data = tx_cnt_q;
            4'd5:    rd_data = rx_cnt_q;
            4'd6:    rd_data = err_cnt_q;
            default: rd_mapped = 1'b0;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            rst_done  <= 1'b0;
            aw_full   <= 1'b0;
            w_full    <= 1'b0;
            wr_idx    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
            ctrl_q    <= '0;
            mac_lo_q  <= '0;
            mac_hi_q  <= '0;
            ifg_q     <= '0;
            tx_cnt_q  <= '0;
            rx_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            rst_done <= 1'b1;

            if (aw_hs) begin
                aw_full <= 1'b1;
                wr_idx  <= S_AXI_AWADDR[5:2];
            end
            if (w_hs) begin
                w_full  <= 1'b1;
                wdata_q <= S_AXI_WDATA;
                wstrb_q <= S_AXI_WSTRB;
            end

            if (commit) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_mapped ? 2'b00 : 2'b10;
                case (wr_idx)
                    4'd0:    ctrl_q   <= apply_strb(ctrl_q, wdata_q, wstrb_q);
                    4'd1:    mac_lo_q <= apply_strb(mac_lo_q, wdata_q, wstrb_q);
                    4'd2:    mac_hi_q <= apply_strb(mac_hi_q, wdata_q, wstrb_q);
                    4'd3:    ifg_q    <= apply_strb(ifg_q, wdata_q, wstrb_q);
                    default: ;
                endcase
            end
            if (b_hs) begin
                bvalid_q <= 1'b0;
                aw_full  <= 1'b0;
                w_full   <= 1'b0;
            end

            tx_cnt_q  <= cnt_next(tx_cnt_q,  tx_frame_i, commit && wr_idx == 4'd4);
            rx_cnt_q  <= cnt_next(rx_cnt_q,  rx_frame_i, commit && wr_idx == 4'd5);
            err_cnt_q <= cnt_next(err_cnt_q, rx_err_i,   commit && wr_idx == 4'd6);

            // Single-cycle ARREADY pulse; RDATA is captured before any same-edge commit
            arready_q <= S_AXI_ARVALID & ~rvalid_q & ~arready_q;
            if (ar_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_data;
                rresp_q  <= rd_mapped ? 2'b00 : 2'b10;
            end else if (r_hs) begin
                rvalid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_eth_10g_axil_regs.sv
// tb/tb_eth_10g_axil_regs.sv - self-checking bench for eth_10g_axil_regs
module tb_eth_10g_axil_regs;
    logic        clk, resetn;
    logic [5:0]  S_AXI_AWADDR, S_AXI_ARADDR;
    logic [2:0]  S_AXI_AWPROT, S_AXI_ARPROT;
    logic        S_AXI_AWVALID, S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID, S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID, S_AXI_BREADY;
    logic        S_AXI_ARVALID, S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID, S_AXI_RREADY;
    logic [31:0] ctrl_o, ifg_o;
    logic [47:0] mac_addr_o;
    logic        tx_frame_i, rx_frame_i, rx_err_i;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] m_rw[4];
    logic [31:0] m_cnt[3];

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          mode;
        logic [1:0]  exp_bresp;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_rresp;
    } vec_t;
    vec_t vecs[11];

    eth_10g_axil_regs dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(resetn),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .ctrl_o(ctrl_o), .mac_addr_o(mac_addr_o), .ifg_o(ifg_o),
        .tx_frame_i(tx_frame_i), .rx_frame_i(rx_frame_i), .rx_err_i(rx_err_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] model_resp(input logic [5:0] a);
        return (a[5:2] < 4'd7) ? 2'b00 : 2'b10;
    endfunction

    function automatic logic [31:0] model_read(input logic [5:0] a);
        int idx = int'(a[5:2]);
        if (idx < 4) return m_rw[idx];
        if (idx < 7) return m_cnt[idx-4];
        return 32'h0;
    endfunction

    task automatic model_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
        int idx = int'(a[5:2]);
        if (idx < 4) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) m_rw[idx][8*b +: 8] = d[8*b +: 8];
        end else if (idx < 7) begin
            m_cnt[idx-4] = 32'h0;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_rw[i] = 32'h0;
        for (int i = 0; i < 3; i++) m_cnt[i] = 32'h0;
    endtask

    // mode 0: AW and W together; 1: W leads by 3 cycles; 2: AW leads by 3 cycles
    task automatic issue_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s, input int mode);
        bit aw_done = 0, w_done = 0, hs_aw, hs_w;
        int aw_dly = (mode == 1) ? 3 : 0;
        int w_dly  = (mode == 2) ? 3 : 0;
        for (int c = 0; c < 30 && !(aw_done && w_done); c++) begin
            if (!aw_done && c >= aw_dly) begin S_AXI_AWADDR = a; S_AXI_AWVALID = 1'b1; end
            if (!w_done && c >= w_dly) begin S_AXI_WDATA = d; S_AXI_WSTRB = s; S_AXI_WVALID = 1'b1; end
            hs_aw = S_AXI_AWVALID && S_AXI_AWREADY;
            hs_w  = S_AXI_WVALID && S_AXI_WREADY;
            step();
            if (hs_aw) begin aw_done = 1; S_AXI_AWVALID = 1'b0; end
            if (hs_w)  begin w_done = 1;  S_AXI_WVALID = 1'b0; end
        end
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        check("aw_w_accept", {aw_done, w_done}, 2'b11);
    endtask

    task automatic wait_b(output logic [1:0] resp);
        bit got = 0;
        resp = 2'b11;
        S_AXI_BREADY = 1'b1;
        for (int n = 0; n < 20 && !got; n++) begin
            if (S_AXI_BVALID) begin resp = S_AXI_BRESP; got = 1; end
            step();
        end
        S_AXI_BREADY = 1'b0;
        check("b_seen", got, 1'b1);
        check("single_b", S_AXI_BVALID, 1'b0);
    endtask

    task automatic issue_read(input logic [5:0] a);
        bit done = 0;
        S_AXI_ARADDR  = a;
        S_AXI_ARVALID = 1'b1;
        for (int n = 0; n < 20 && !done; n++) begin
            done = S_AXI_ARREADY;
            step();
        end
        S_AXI_ARVALID = 1'b0;
        check("ar_accept", done, 1'b1);
    endtask

    task automatic wait_r(output logic [31:0] d, output logic [1:0] resp);
        bit got = 0;
        d = 32'hx;
        resp = 2'b11;
        S_AXI_RREADY = 1'b1;
        for (int n = 0; n < 20 && !got; n++) begin
            if (S_AXI_RVALID) begin d = S_AXI_RDATA; resp = S_AXI_RRESP; got = 1; end
            step();
        end
        S_AXI_RREADY = 1'b0;
        check("r_seen", got, 1'b1);
    endtask

    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int mode, output logic [1:0] resp);
        issue_write(a, d, s, mode);
        wait_b(resp);
        model_write(a, d, s);
    endtask

    task automatic axi_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] resp);
        issue_read(a);
        wait_r(d, resp);
    endtask

    task automatic pulse(input logic tx, input logic rx, input logic er);
        tx_frame_i = tx; rx_frame_i = rx; rx_err_i = er;
        step();
        tx_frame_i = 1'b0; rx_frame_i = 1'b0; rx_err_i = 1'b0;
        if (tx && m_cnt[0] != 32'hFFFF_FFFF) m_cnt[0] = m_cnt[0] + 1;
        if (rx && m_cnt[1] != 32'hFFFF_FFFF) m_cnt[1] = m_cnt[1] + 1;
        if (er && m_cnt[2] != 32'hFFFF_FFFF) m_cnt[2] = m_cnt[2] + 1;
    endtask

    initial begin
        logic [1:0]  br, rr;
        logic [31:0] rd;
        logic [5:0]  ra;
        bit          stale;

        vecs[0]  = '{6'h00, 32'd1,          4'hF, 0, 2'b00, 32'd1,          2'b00};
        vecs[1]  = '{6'h04, 32'd2,          4'hF, 0, 2'b00, 32'd2,          2'b00};
        vecs[2]  = '{6'h08, 32'd3,          4'hF, 0, 2'b00, 32'd3,          2'b00};
        vecs[3]  = '{6'h0C, 32'd4,          4'hF, 0, 2'b00, 32'd4,          2'b00};
        vecs[4]  = '{6'h0C, 32'h11223344,   4'hF, 0, 2'b00, 32'h11223344,   2'b00};
        vecs[5]  = '{6'h0C, 32'hAABBCCDD,   4'h5, 0, 2'b00, 32'h11BB33DD,   2'b00};
        vecs[6]  = '{6'h0F, 32'h11223344,   4'hF, 2, 2'b00, 32'h11223344,   2'b00};
        vecs[7]  = '{6'h0C, 32'hAABBCCDD,   4'h5, 1, 2'b00, 32'h11BB33DD,   2'b00};
        vecs[8]  = '{6'h0D, 32'h11223344,   4'hF, 1, 2'b00, 32'h11223344,   2'b00};
        vecs[9]  = '{6'h0C, 32'hAABBCCDD,   4'h5, 2, 2'b00, 32'h11BB33DD,   2'b00};
        vecs[10] = '{6'h20, 32'hDEADBEEF,   4'hF, 0, 2'b10, 32'h0,          2'b10};

        resetn = 1'b0;
        S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = '0;  S_AXI_WSTRB = '0;  S_AXI_WVALID = 1'b0;
        S_AXI_BREADY = 1'b0;
        S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY = 1'b0;
        tx_frame_i = 1'b0; rx_frame_i = 1'b0; rx_err_i = 1'b0;
        model_reset();

        for (int i = 0; i < 20; i++) begin
            step();
            check("reset_outputs", {S_AXI_BVALID, S_AXI_RVALID, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 5'b0);
        end
        resetn = 1'b1;
        step();

        for (int a = 0; a < 7; a++) begin
            axi_read(6'(a * 4), rd, rr);
            check("reset_read", {rd, rr}, {32'h0, 2'b00});
        end

        for (int i = 0; i < 11; i++) begin
            axi_write(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, vecs[i].mode, br);
            check($sformatf("vec%0d_bresp", i), br, vecs[i].exp_bresp);
            axi_read(vecs[i].addr, rd, rr);
            check($sformatf("vec%0d_read", i), {rd, rr}, {vecs[i].exp_rdata, vecs[i].exp_rresp});
            if (i == 3) begin
                check("ctrl_o", ctrl_o, 32'd1);
                check("mac_addr_o", mac_addr_o, 48'h0003_00000002);
                check("ifg_o", ifg_o, 32'd4);
            end
        end
        for (int a = 0; a < 4; a++) begin
            axi_read(6'(a * 4), rd, rr);
            check("unmapped_no_effect", {rd, rr}, {model_read(6'(a * 4)), 2'b00});
        end

        for (int i = 0; i < 5; i++) pulse(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) pulse(1'b0, 1'b0, 1'b1);
        axi_read(6'h14, rd, rr);
        check("rx_cnt", {rd, rr}, {32'd5, 2'b00});
        axi_read(6'h18, rd, rr);
        check("err_cnt", {rd, rr}, {32'd2, 2'b00});
        axi_read(6'h10, rd, rr);
        check("tx_cnt", {rd, rr}, {32'd0, 2'b00});

        // Clear of RX_CNT lands on the same edge as an rx_frame pulse
        S_AXI_AWADDR = 6'h14; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = 32'h0;  S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        check("clr_aw_ready", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b11);
        step();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        rx_frame_i = 1'b1;
        step();
        rx_frame_i = 1'b0;
        check("clr_commit_bvalid", S_AXI_BVALID, 1'b1);
        wait_b(br);
        m_cnt[1] = 32'h0;
        axi_read(6'h14, rd, rr);
        check("rx_clear_wins", {rd, rr}, {32'd0, 2'b00});

        for (int it = 0; it < 60; it++) begin
            ra = {4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            case ($urandom_range(0, 2))
                0: begin
                    logic [31:0] d = $urandom;
                    logic [3:0]  s = 4'($urandom_range(0, 15));
                    axi_write(ra, d, s, int'($urandom_range(0, 2)), br);
                    check("rand_bresp", br, model_resp(ra));
                end
                1: begin
                    axi_read(ra, rd, rr);
                    check("rand_read", {rd, rr}, {model_read(ra), model_resp(ra)});
                end
                default: begin
                    for (int k = 0; k < int'($urandom_range(1, 4)); k++)
                        pulse(1'($urandom), 1'($urandom), 1'($urandom));
                end
            endcase
        end
        for (int a = 0; a < 7; a++) begin
            axi_read(6'(a * 4), rd, rr);
            check("rand_final", {rd, rr}, {model_read(6'(a * 4)), 2'b00});
        end
        check("rand_outputs", {ctrl_o, ifg_o}, {m_rw[0], m_rw[3]});
        check("rand_mac", mac_addr_o, {m_rw[2][15:0], m_rw[1]});

        // Back-pressure on both response channels, then reset while held
        issue_write(6'h04, 32'hCAFEF00D, 4'hF, 0);
        for (int n = 0; n < 10 && !S_AXI_BVALID; n++) step();
        check("hold_b_up", S_AXI_BVALID, 1'b1);
        model_write(6'h04, 32'hCAFEF00D, 4'hF);
        issue_read(6'h04);
        check("hold_r_up", S_AXI_RVALID, 1'b1);
        S_AXI_ARADDR = 6'h00; S_AXI_ARVALID = 1'b1;
        for (int n = 0; n < 10; n++) begin
            check("hold_stable",
                  {S_AXI_BVALID, S_AXI_RVALID, S_AXI_BRESP, S_AXI_RRESP,
                   S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_RDATA},
                  {1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 32'hCAFEF00D});
            step();
        end
        resetn = 1'b0;
        step();
        check("reset_drop", {S_AXI_BVALID, S_AXI_RVALID, S_AXI_ARREADY}, 3'b0);
        S_AXI_ARVALID = 1'b0;
        step();
        resetn = 1'b1;
        model_reset();
        S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
        stale = 0;
        for (int n = 0; n < 10; n++) begin
            step();
            stale = stale | S_AXI_BVALID | S_AXI_RVALID;
        end
        S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
        check("no_stale_resp", stale, 1'b0);
        axi_read(6'h04, rd, rr);
        check("post_reset_mac_lo", {rd, rr}, {model_read(6'h04), 2'b00});
        axi_read(6'h18, rd, rr);
        check("post_reset_err_cnt", {rd, rr}, {model_read(6'h18), 2'b00});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/eth_10g_axil_regs.md
Name: eth_10g_axil_regs

Overview:
AXI4-Lite slave register file for the eth_10g core. It terminates the control-plane master and exposes four read/write configuration registers and three read-only statistics counters. Configuration outputs drive the MAC datapath, and the MAC returns one-cycle event pulses that the counters accumulate. The block is the direct downstream consumer of the AXI4-Lite master used in the block-design bench.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 6, byte address width; gives a 64-byte window of 16 words.

Ports:
S_AXI_ACLK  in  1  clock; all logic is on its rising edge.
S_AXI_ARESETN  in  1  synchronous active-low reset.
S_AXI_AWADDR  in  6  write address.
S_AXI_AWPROT  in  3  ignored.
S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake.
S_AXI_WDATA  in  32  write data.
S_AXI_WSTRB  in  4  byte enables.
S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake.
S_AXI_BRESP  out  2  write response: 00 OKAY, 10 SLVERR.
S_AXI_BVALID / S_AXI_BREADY  out / in  1  write-response handshake.
S_AXI_ARADDR  in  6  read address.
S_AXI_ARPROT  in  3  ignored.
S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake.
S_AXI_RDATA  out  32  read data.
S_AXI_RRESP  out  2  read response: 00 OKAY, 10 SLVERR.
S_AXI_RVALID / S_AXI_RREADY  out / in  1  read-data handshake.
ctrl_o  out  32  REG0 contents.
mac_addr_o  out  48  {REG2[15:0], REG1}.
ifg_o  out  32  REG3 contents.
tx_frame_i  in  1  one-cycle pulse per transmitted frame.
rx_frame_i  in  1  one-cycle pulse per good received frame.
rx_err_i  in  1  one-cycle pulse per bad received frame.

Behaviour:
- Register map, word index = ADDR[5:2]; ADDR[1:0] ignored:
  - 0x00 CTRL: RW.
  - 0x04 MAC_LO: RW.
  - 0x08 MAC_HI: RW; all 32 bits are stored and read back.
  - 0x0C IFG: RW.
  - 0x10 TX_CNT, 0x14 RX_CNT, 0x18 ERR_CNT: RO counters; any write clears the counter.
  - 0x1C–0x3C: unmapped.
- Reset: while S_AXI_ARESETN=0 at a clock edge, all registers, counters, READY, VALID and RESP outputs go to 0. Any in-flight transaction is dropped, and no response is given for it after reset.
- Write channel:
  - AW and W are accepted independently. AWREADY=1 while no address is latched and BVALID=0; WREADY=1 under the same rule for data.
  - Each handshake latches its channel. AW-before-W, W-before-AW and simultaneous arrival are all legal.
  - Commit happens in the cycle after both address and data are latched: byte lanes with WSTRB set update an RW register. BVALID rises in that same cycle.
  - BRESP is OKAY for mapped addresses and SLVERR for unmapped ones. Unmapped writes have no effect.
  - BVALID holds until BREADY; both latches clear on the B handshake. Only one write is outstanding at a time.
- Read channel:
  - ARREADY=1 for exactly one cycle when ARVALID=1, RVALID=0 and ARREADY=0.
  - RVALID rises in the cycle after the AR handshake, with RDATA sampled at that point.
  - RDATA/RRESP hold until RREADY. Unmapped reads return 0 with SLVERR.
  - Read-to-read gap is at least 2 cycles. Reads and writes proceed concurrently and do not interlock.
- Counters:
  - 32-bit; +1 per cycle in which the matching pulse is high; saturate at 0xFFFFFFFF and do not wrap.
  - Clear-on-write and a pulse in the same cycle: the clear wins and the counter becomes 0.
- Same-cycle read of a register being committed returns the old value, because RDATA is registered before the commit.
- Outputs ctrl_o, mac_addr_o and ifg_o are taken straight from the registers and change the cycle after the commit.

Test Plan:
- Reset for 20 cycles, then release and read 0x00–0x18 → all return 0 with OKAY; no BVALID/RVALID seen during reset.
- Write 1, 2, 3, 4 to 0x00, 0x04, 0x08, 0x0C, then read them back → 1, 2, 3, 4 with OKAY; mac_addr_o=0x0003_00000002, ifg_o=4.
- Write 0xAABBCCDD to 0x0C with WSTRB=0101 over old value 0x11223344 → readback 0x11BB33DD. Repeat with W issued 3 cycles before AW and with AW issued 3 cycles before W → identical result, one B per write.
- Pulse rx_frame_i 5 times and rx_err_i 2 times → RX_CNT=5, ERR_CNT=2. Write 0x14 in the same cycle as an rx_frame_i pulse → RX_CNT=0.
- Write and read at 0x20 → BRESP=10, RRESP=10, RDATA=0; registers unchanged.
- Hold BREADY/RREADY low for 10 cycles → BVALID/RVALID and data stay stable, and no new AW/AR is accepted. Assert reset mid-hold → VALIDs drop next edge and no stale response follows.
